// File: rtl/adder_operand_loader.sv
// Operand loader for tt_um_adder: synchronises a nibble bus and a load strobe,
// captures operand A then B, and presents the pair with a valid/ready handshake.
module adder_operand_loader #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             load,
   input  logic             clr_ovr,
   input  logic             op_ready,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_valid,
   output logic             overrun,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      WAIT_A = 2'b00,
      WAIT_B = 2'b01,
      HOLD   = 2'b10,
      BAD    = 2'b11
   } state_t;

   logic [WIDTH-1:0]       din_sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]       din_sync_d [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] load_sync_q;
   logic [SYNC_STAGES-1:0] load_sync_d;
   logic                   load_prev_q;
   logic                   load_prev_d;

   state_t                 state_q;
   state_t                 state_d;
   logic [WIDTH-1:0]       op_a_q;
   logic [WIDTH-1:0]       op_a_d;
   logic [WIDTH-1:0]       op_b_q;
   logic [WIDTH-1:0]       op_b_d;
   logic                   op_valid_q;
   logic                   op_valid_d;
   logic                   overrun_q;
   logic                   overrun_d;

   logic                   load_synced;
   logic [WIDTH-1:0]       din_synced;
   logic                   ld_pulse;
   logic                   ovr_set;

   // Both paths share the same depth so din is aligned with the strobe edge.
   always_comb begin
      din_sync_d[0] = din;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
         din_sync_d[i] = din_sync_q[i-1];
      end
      load_sync_d = {load_sync_q[SYNC_STAGES-2:0], load};
      load_synced = load_sync_q[SYNC_STAGES-1];
      din_synced  = din_sync_q[SYNC_STAGES-1];
      load_prev_d = load_synced;
      ld_pulse    = load_synced & ~load_prev_q;
   end

   // Load path resets high so a strobe held across reset release is not an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            din_sync_q[i] <= '0;
         end
         load_sync_q <= '1;
         load_prev_q <= 1'b1;
      end else begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            din_sync_q[i] <= din_sync_d[i];
         end
         load_sync_q <= load_sync_d;
         load_prev_q <= load_prev_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      op_valid_d = op_valid_q;
      ovr_set    = 1'b0;

      case (state_q)
         WAIT_A: begin
            op_valid_d = 1'b0;
            if (ld_pulse) begin
               op_a_d  = din_synced;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            op_valid_d = 1'b0;
            if (ld_pulse) begin
               op_b_d     = din_synced;
               op_valid_d = 1'b1;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (op_valid_q && op_ready) begin
               // Transfer; a coincident strobe starts the next pair instead of overrunning.
               op_valid_d = 1'b0;
               if (ld_pulse) begin
                  op_a_d  = din_synced;
                  state_d = WAIT_B;
               end else begin
                  state_d = WAIT_A;
               end
            end else if (ld_pulse) begin
               ovr_set = 1'b1;
            end
         end
         BAD: begin
            op_valid_d = 1'b0;
            state_d    = WAIT_A;
         end
      endcase

      overrun_d = overrun_q;
      if (ovr_set) begin
         overrun_d = 1'b1;
      end else if (clr_ovr) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= WAIT_A;
         op_a_q     <= '0;
         op_b_q     <= '0;
         op_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         op_valid_q <= op_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign op_a      = op_a_q;
   assign op_b      = op_b_q;
   assign op_valid  = op_valid_q;
   assign overrun   = overrun_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed-vector bench for adder_operand_loader (WIDTH=4, SYNC_STAGES=2).
module tb_adder_operand_loader;

   logic       clk;
   logic       reset;
   logic [3:0] din;
   logic       load;
   logic       clr_ovr;
   logic       op_ready;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic       op_valid;
   logic       overrun;
   logic [1:0] state_dbg;

   int unsigned n_vec;
   int unsigned n_miss;

   adder_operand_loader #(
      .WIDTH       (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .load      (load),
      .clr_ovr   (clr_ovr),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .op_valid  (op_valid),
      .overrun   (overrun),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Full strobe: load high 4 cycles, low 4 cycles; capture completes inside.
   task automatic strobe(input logic [3:0] d);
      @(negedge clk);
      din  = d;
      load = 1'b1;
      repeat (4) @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      n_vec    = 0;
      n_miss   = 0;
      reset    = 1'b1;
      din      = 4'h0;
      load     = 1'b1;
      clr_ovr  = 1'b0;
      op_ready = 1'b0;

      // Reset state, then release with load still high
      repeat (3) @(negedge clk);
      chk("rst_state", state_dbg, 2'b00);
      chk("rst_op_a", op_a, 4'h0);
      chk("rst_op_b", op_b, 4'h0);
      chk("rst_valid", op_valid, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("held_load_state", state_dbg, 2'b00);
      chk("held_load_op_a", op_a, 4'h0);
      chk("held_load_valid", op_valid, 1'b0);
      load = 1'b0;
      repeat (4) @(negedge clk);

      // Operand A latency: visible after the third rising edge
      din  = 4'h3;
      load = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("lat_e2_op_a", op_a, 4'h0);
      chk("lat_e2_state", state_dbg, 2'b00);
      @(negedge clk);
      chk("lat_e3_op_a", op_a, 4'h3);
      chk("lat_e3_state", state_dbg, 2'b01);
      repeat (2) @(negedge clk);
      load = 1'b0;
      repeat (4) @(negedge clk);

      strobe(4'h5);
      chk("b_op_a", op_a, 4'h3);
      chk("b_op_b", op_b, 4'h5);
      chk("b_valid", op_valid, 1'b1);
      chk("b_state", state_dbg, 2'b10);
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      chk("xfer_valid", op_valid, 1'b0);
      chk("xfer_state", state_dbg, 2'b00);
      chk("xfer_op_a", op_a, 4'h3);
      chk("xfer_op_b", op_b, 4'h5);

      // Overrun in HOLD
      strobe(4'h3);
      strobe(4'h5);
      chk("hold2_state", state_dbg, 2'b10);
      strobe(4'hF);
      chk("ovr_set", overrun, 1'b1);
      chk("ovr_op_a", op_a, 4'h3);
      chk("ovr_op_b", op_b, 4'h5);
      chk("ovr_state", state_dbg, 2'b10);
      chk("ovr_valid", op_valid, 1'b1);
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      chk("ovr_clr", overrun, 1'b0);

      // clr_ovr coincident with a new overrun: set wins
      din  = 4'hE;
      load = 1'b1;
      @(negedge clk);
      @(negedge clk);
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      chk("ovr_set_wins", overrun, 1'b1);
      load = 1'b0;
      repeat (4) @(negedge clk);
      chk("ovr_sticky", overrun, 1'b1);
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      chk("ovr_clr2", overrun, 1'b0);

      // Strobe and op_ready together in HOLD
      din  = 4'h9;
      load = 1'b1;
      @(negedge clk);
      @(negedge clk);
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      load     = 1'b0;
      chk("hs_valid", op_valid, 1'b0);
      chk("hs_op_a", op_a, 4'h9);
      chk("hs_op_b", op_b, 4'h5);
      chk("hs_state", state_dbg, 2'b01);
      chk("hs_ovr", overrun, 1'b0);
      repeat (4) @(negedge clk);

      // op_ready outside HOLD is ignored
      op_ready = 1'b1;
      repeat (2) @(negedge clk);
      op_ready = 1'b0;
      chk("rdy_ign_state", state_dbg, 2'b01);
      chk("rdy_ign_valid", op_valid, 1'b0);

      // Finish pair, transfer, then reset mid-sequence in WAIT_B
      strobe(4'h1);
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;
      chk("pre_rst_state", state_dbg, 2'b00);
      strobe(4'h7);
      chk("wb_op_a", op_a, 4'h7);
      chk("wb_state", state_dbg, 2'b01);
      #2;
      reset = 1'b1;
      #1;
      chk("async_op_a", op_a, 4'h0);
      chk("async_op_b", op_b, 4'h0);
      chk("async_state", state_dbg, 2'b00);
      chk("async_valid", op_valid, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      strobe(4'h1);
      strobe(4'h2);
      chk("post_rst_op_a", op_a, 4'h1);
      chk("post_rst_op_b", op_b, 4'h2);
      chk("post_rst_valid", op_valid, 1'b1);
      chk("post_rst_state", state_dbg, 2'b10);
      op_ready = 1'b1;
      @(negedge clk);
      op_ready = 1'b0;

      // Glitch between clock edges is not sampled
      @(negedge clk);
      din = 4'hA;
      #1 load = 1'b1;
      #3 load = 1'b0;
      repeat (6) @(negedge clk);
      chk("glitch_state", state_dbg, 2'b00);
      chk("glitch_op_a", op_a, 4'h1);

      // Long strobe: exactly one capture
      din  = 4'hC;
      load = 1'b1;
      repeat (50) @(negedge clk);
      chk("long_state", state_dbg, 2'b01);
      chk("long_op_a", op_a, 4'hC);
      chk("long_op_b", op_b, 4'h2);
      load = 1'b0;
      repeat (6) @(negedge clk);
      chk("long_after_state", state_dbg, 2'b01);
      chk("long_after_valid", op_valid, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
